bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits between the 16-bit binary counter and the per-digit `hexdigit` decoders, so the 7-segment display can show the count in decimal instead of hex. It converts one value per `start` request and holds the result for the digit decoders until the next conversion completes. It also produces a leading-zero mask so the display stage can blank unused digits with code 20.

## Interface
- `WIDTH`, 16: binary input width in bits.
- `DIGITS`, 5: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- `clk`  in  1: system clock (10 MHz on the board). All logic is on the rising edge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-low.
- `start`  in  1: conversion request, sampled on the rising edge of `clk`.
- `bin`  in  WIDTH: binary value, captured on the cycle `start` is accepted.
- `busy`  out  1: high while a conversion is in progress (SHIFT and DONE states).
- `done`  out  1: one-cycle pulse when `bcd` and `zmask` are updated.
- `bcd`  out  4*DIGITS: result. Digit i occupies bits [4i+3:4i]; digit 0 is the least significant.
- `zmask`  out  DIGITS: bit i is 1 when digit i is a leading zero. Bit 0 is always 0.

## Operation
- Reset values: `busy`=0, `done`=0, `bcd`=0, `zmask`={DIGITS-1{1'b1}},1'b0. State is IDLE and the internal shift registers are 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if `start`=1, load `bin` into the binary shift register, clear the BCD scratch register, clear the shift counter, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, first apply the add-3 correction to every scratch digit that is ≥ 5. Then shift the concatenation {scratch, binary} left by 1, so the binary MSB enters scratch bit 0. Increment the shift counter. After the WIDTH-th shift, go to DONE.
  - DONE: register the scratch value into `bcd` and compute `zmask` into its register. Assert `done` for this cycle only. Go to IDLE.
- `start` is ignored while `busy`=1, including in the DONE cycle. No queuing.
- `bin` is only sampled on the accept edge. Later changes do not affect the conversion in progress.
- `bcd` and `zmask` hold their values between conversions. They change only in DONE or on reset.
- `zmask` rule: bit i (i ≥ 1) is 1 iff digits i..DIGITS-1 are all 0.
- Arithmetic:
  - The scratch register is 4*DIGITS bits. The shift counter is $clog2(WIDTH+1) bits.
  - The add-3 correction is per nibble, with no carry between nibbles.
  - Digits never exceed 9 after a complete conversion.
- Reset asserted mid-conversion abandons the conversion and forces all reset values; no `done` is issued.

## Timing
- `start` accepted at edge k.
- `busy`=1 from edge k+1 through edge k+WIDTH+1.
- The SHIFT state covers cycles k+1 … k+WIDTH.
- DONE occupies cycle k+WIDTH+1. `done`=1, and `bcd`/`zmask` are valid from edge k+WIDTH+1.
- Latency from `start` to `done` is WIDTH+1 cycles (17 for the default).
- The earliest next accept is edge k+WIDTH+2, giving a throughput of one conversion per WIDTH+2 cycles.
- Outputs are fully registered; there are no combinational paths from input to output.

## Structure
- Shared header `count_defs.vh` holds:
  - the FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the blank digit code 20, which the display glue uses together with `zmask`.
- Sub-module `bcd_add3`: a purely combinational 4-bit in / 4-bit out block that outputs in+3 when in ≥ 5 and in otherwise. It is instantiated DIGITS times in a generate loop.
- The top of the design instantiates one `bin2bcd_seq`. `start` is driven by a one-cycle pulse generated on each 1 Hz counter increment.

## Test plan
- Reset release, no `start`:
  - `bcd`=0, `zmask`=5'b11110, `busy`=0, `done`=0 are held indefinitely.
- `bin`=16'd65535, `start` pulse:
  - `done` arrives exactly 17 cycles later with `bcd`=20'h65535 and `zmask`=5'b00000.
  - `busy` is high for exactly 17 cycles.
- `bin`=16'd0, then `bin`=16'd9, then `bin`=16'd10, each converted:
  - results are `bcd`=20'h00000 with `zmask`=5'b11110, then `bcd`=20'h00009 with `zmask`=5'b11110, then `bcd`=20'h00010 with `zmask`=5'b11100.
- `bin`=16'd1234 accepted, then `start` held high with `bin`=16'd999 for 17 cycles:
  - the result is 20'h01234, because the second request is ignored while busy.
  - With `start` still high, the next accept happens in the cycle after DONE.
- Mid-conversion reset: `bin`=16'd4321 accepted, `rst` pulled low at cycle k+8:
  - all outputs return to reset values immediately.
  - no `done` occurs.
  - a fresh `start` after release gives 20'h04321 with the normal latency.
- Randomised regression: 1000 random `bin` values checked against a reference decimal conversion, plus checks that digits are ≤ 9 and that `zmask` is consistent with `bcd`.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t    : converter FSM states (IDLE=0, SHIFT=1, DONE=2)
//   BLANK_CODE : digit code the display glue substitutes for a masked
//                leading-zero digit (used together with zmask)
// ---------------------------------------------------------------------------
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] BLANK_CODE = 5'd20;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
// Request/result bundle between a value producer and the converter.
//   start : conversion request (producer -> converter)
//   bin   : binary value, sampled when start is accepted
//   busy  : conversion in progress (converter -> producer)
//   done  : one-cycle pulse when bcd/zmask are updated
//   bcd   : packed BCD result, digit i in bits [4i+3:4i]
//   zmask : bit i set when digit i is a leading zero (bit 0 always clear)
// Modports: master = producer side, slave = converter side.
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     zmask;

  modport master (
    output start, bin,
    input  busy, done, bcd, zmask
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, zmask
  );
endinterface

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Double-dabble correction for one BCD digit: a digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit. Purely combinational.
//   digit    : 4-bit scratch digit before correction
//   adjusted : digit + 3 when digit >= 5, digit otherwise
// ---------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-and-add-3 binary-to-BCD converter. One conversion per
// accepted start; the result and leading-zero mask are held until the next
// conversion completes. Latency start->done is WIDTH+1 cycles, throughput one
// conversion per WIDTH+2 cycles. All outputs are registered.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : bin2bcd_seq_if slave (start/bin in; busy/done/bcd/zmask out)
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int                  CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]    LAST_SHIFT = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0]   ZMASK_RST  = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t                state;
  logic [WIDTH-1:0]      bin_sr;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adjusted;
  logic [CNT_W-1:0]      cnt;
  logic                  busy_q;
  logic                  done_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [DIGITS-1:0]     zmask_q;
  logic [DIGITS-1:0]     zmask_next;

  // Per-digit add-3 correction, no carry between nibbles.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (scratch[4*g +: 4]),
      .adjusted (adjusted[4*g +: 4])
    );
  end

  // Leading-zero mask from the finished scratch value: walk down from the
  // most significant digit while every digit seen so far is zero. Digit 0 is
  // never blanked so a value of 0 still shows a single "0".
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    logic upper_zero;
    zmask_next = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (scratch[4*i +: 4] == 4'd0);
      zmask_next[i] = upper_zero;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      zmask_q <= ZMASK_RST;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr  <= bus.bin;
            scratch <= '0;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct first, then shift {scratch, bin_sr} left by one.
          scratch <= {adjusted[4*DIGITS-2:0], bin_sr[WIDTH-1]};
          bin_sr  <= bin_sr << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_SHIFT) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= scratch;
          zmask_q <= zmask_next;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.zmask = zmask_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Scoreboard bench for bin2bcd_seq. The driver pushes the decimal expectation
// when a request is accepted; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int WIDTH   = 16;
  localparam int DIGITS  = 5;
  localparam int LATENCY = WIDTH + 1;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   zmask;
    int                  accept;
    int                  value;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain decimal digit extraction.
  function automatic exp_t model(input int value, input int accept);
    exp_t e;
    int   t;
    e.bcd    = '0;
    e.zmask  = '0;
    e.accept = accept;
    e.value  = value;
    t = value;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    for (int i = 1; i < DIGITS; i++) begin
      e.zmask[i] = (value < 10 ** i);
    end
    return e;
  endfunction

  // Monitor: compare every done pulse with the oldest expectation.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d, bcd=%0h)",
                 cyc, bus.bcd);
      end else begin
        exp_t                e;
        logic                digits_ok;
        logic [DIGITS-1:0]   z_from_bcd;
        e = sb.pop_front();
        check($sformatf("bcd[%0d]", e.value), 32'(bus.bcd), 32'(e.bcd));
        check($sformatf("zmask[%0d]", e.value), 32'(bus.zmask), 32'(e.zmask));
        check($sformatf("latency[%0d]", e.value), 32'(cyc - e.accept), 32'(LATENCY));
        digits_ok  = 1'b1;
        z_from_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
          if (bus.bcd[4*i +: 4] > 4'd9) digits_ok = 1'b0;
        end
        for (int i = 1; i < DIGITS; i++) begin
          z_from_bcd[i] = ((bus.bcd >> (4 * i)) == '0);
        end
        check("digit_range", 32'(digits_ok), 32'd1);
        check("zmask_vs_bcd", 32'(bus.zmask), 32'(z_from_bcd));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
    end
  endtask

  // Issue one request at a negedge while idle; returns the accept edge.
  task automatic issue(input int value, output int accept);
    wait_idle();
    bus.bin   = WIDTH'(value);
    bus.start = 1'b1;
    accept    = cyc + 1;
    sb.push_back(model(value, accept));
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = WIDTH'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
    check({tag, "_bcd"},   32'(bus.bcd),   32'd0);
    check({tag, "_zmask"}, 32'(bus.zmask), 32'b11110);
  endtask

  initial begin
    int k;
    int n;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: values held with no request.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_values("idle");
    end

    // Full-scale value, busy window length.
    issue(65535, k);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(LATENCY));
    drain();

    // Small boundary values.
    issue(0, k);
    drain();
    issue(9, k);
    drain();
    issue(10, k);
    drain();

    // Request held high while busy: second value accepted only after DONE.
    wait_idle();
    bus.bin   = WIDTH'(1234);
    bus.start = 1'b1;
    k = cyc + 1;
    sb.push_back(model(1234, k));
    sb.push_back(model(999, k + WIDTH + 2));
    @(negedge clk);
    bus.bin = WIDTH'(999);
    repeat (WIDTH + 1) @(negedge clk);
    check("held_start_idle_before_reaccept", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("held_start_reaccept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    drain();

    // Mid-conversion reset abandons the conversion.
    issue(4321, k);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_no_busy", 32'(bus.busy), 32'd0);
    issue(4321, k);
    drain();

    // Randomised regression, back to back.
    for (int i = 0; i < 1000; i++) begin
      issue(int'($urandom_range(65535, 0)), k);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
